// File: rtl/vga_fb_fetch.sv
// Framebuffer fetch stage: Wishbone classic read master that streams one
// 32-bit word per pixel, in raster order, into a first-word-fall-through FIFO.
module vga_fb_fetch #(
    parameter int          HDISP      = 640,
    parameter int          VDISP      = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 256
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        frame_start,
    input  logic        pix_rd,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        pix_empty,
    output logic        underflow,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int NWORDS = HDISP * VDISP;
    localparam int IW     = $clog2(NWORDS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, DONE, FLUSH} state_t;

    state_t          state, state_nxt;
    logic            req;
    logic [IW-1:0]   idx;
    logic [31:0]     adr;
    logic [23:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic            push_vld;
    logic [23:0]     push_dat;
    logic            take, flush, issue, pop, restart;
    logic            unused_bits;

    assign unused_bits = ^wb_dat_i[31:24];
    assign pop         = pix_rd && !pix_empty;
    assign restart     = flush || (state == IDLE && frame_start);

    always_ff @(posedge CLK) begin
        if (!NRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (frame_start) state_nxt = FETCH;
            FETCH: begin
                // An outstanding request must complete before the FIFO can be flushed.
                if (frame_start)                        state_nxt = (req && !wb_ack) ? DRAIN : FLUSH;
                else if (req && wb_ack && idx == LAST_IDX) state_nxt = DONE;
            end
            DRAIN: if (req && wb_ack) state_nxt = FLUSH;
            DONE:  if (frame_start) state_nxt = FLUSH;
            FLUSH: state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        take  = 1'b0;
        issue = 1'b0;
        flush = 1'b0;
        case (state)
            FETCH: begin
                take  = req && wb_ack && !frame_start;
                // Room check includes the word still sitting in the push stage.
                issue = !req && !frame_start &&
                        (int'(count) + int'(push_vld) + 1 <= FIFO_DEPTH);
            end
            FLUSH: flush = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            req       <= 1'b0;
            idx       <= '0;
            adr       <= BASE_ADDR;
            push_vld  <= 1'b0;
            push_dat  <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (issue)              req <= 1'b1;
            else if (req && wb_ack) req <= 1'b0;

            push_vld <= take;
            if (take) push_dat <= wb_dat_i[23:0];

            if (restart) begin
                idx <= '0;
                adr <= BASE_ADDR;
            end else if (take) begin
                idx <= idx + IW'(1);
                adr <= adr + 32'd4;
            end

            if (flush) begin
                wptr      <= '0;
                rptr      <= '0;
                count     <= '0;
                underflow <= 1'b0;
            end else begin
                if (push_vld) wptr <= wptr + AW'(1);
                if (pop)      rptr <= rptr + AW'(1);
                case ({push_vld, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: ;
                endcase
                if (pix_rd && pix_empty) underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push_vld) mem[wptr] <= push_dat;
    end

    always_ff @(posedge CLK) begin
        if (NRST) assert (count <= (AW+1)'(FIFO_DEPTH));
    end

    assign pix_empty = (count == '0);
    assign {pix_r, pix_g, pix_b} = pix_empty ? 24'h0 : mem[rptr];
    assign wb_cyc = req;
    assign wb_stb = req;
    assign wb_we  = 1'b0;
    assign wb_sel = 4'hF;
    assign wb_adr = adr;
endmodule

// File: tb/tb_vga_fb_fetch.sv
// Directed bench: instance a (640x480, base 0) covers fill/backpressure,
// instance b (8x4, base 0x10000) covers full frame, underflow, drain and reset.
module tb_vga_fb_fetch;
    localparam logic [31:0] BASE_B = 32'h0001_0000;

    logic CLK = 1'b0;
    logic NRST = 1'b0;
    always #5 CLK = ~CLK;

    logic        fs_a = 1'b0, rd_a = 1'b0;
    logic [7:0]  a_r, a_g, a_b;
    logic        a_empty, a_under, a_cyc, a_stb, a_we, a_ack;
    logic [3:0]  a_sel;
    logic [31:0] a_adr, a_dat;

    logic        fs_b = 1'b0, rd_b = 1'b0;
    logic [7:0]  b_r, b_g, b_b;
    logic        b_empty, b_under, b_cyc, b_stb, b_we, b_ack;
    logic [3:0]  b_sel;
    logic [31:0] b_adr, b_dat;

    int          lat_a = 1, lat_b = 3;
    logic        go_b = 1'b0;
    int          wcnt_a = 0, wcnt_b = 0, acks_a = 0, acks_b = 0;
    logic [31:0] last_b = '0;
    int          vectors = 0, miscompares = 0;
    int          snap;

    vga_fb_fetch u_a (
        .CLK(CLK), .NRST(NRST), .frame_start(fs_a), .pix_rd(rd_a),
        .pix_r(a_r), .pix_g(a_g), .pix_b(a_b), .pix_empty(a_empty), .underflow(a_under),
        .wb_cyc(a_cyc), .wb_stb(a_stb), .wb_we(a_we), .wb_sel(a_sel), .wb_adr(a_adr),
        .wb_dat_i(a_dat), .wb_ack(a_ack)
    );

    vga_fb_fetch #(.HDISP(8), .VDISP(4), .BASE_ADDR(BASE_B), .FIFO_DEPTH(256)) u_b (
        .CLK(CLK), .NRST(NRST), .frame_start(fs_b), .pix_rd(rd_b),
        .pix_r(b_r), .pix_g(b_g), .pix_b(b_b), .pix_empty(b_empty), .underflow(b_under),
        .wb_cyc(b_cyc), .wb_stb(b_stb), .wb_we(b_we), .wb_sel(b_sel), .wb_adr(b_adr),
        .wb_dat_i(b_dat), .wb_ack(b_ack)
    );

    // Memory models: word k holds k; top byte is junk the DUT must drop.
    assign a_ack = a_stb && (wcnt_a == lat_a - 1);
    assign a_dat = {8'hA5, 24'(a_adr >> 2)};
    assign b_ack = b_stb && ((lat_b != 0) ? (wcnt_b == lat_b - 1) : go_b);
    assign b_dat = {8'h5A, 24'((b_adr - BASE_B) >> 2)};

    always @(posedge CLK) begin
        wcnt_a <= (a_stb && !a_ack) ? wcnt_a + 1 : 0;
        wcnt_b <= (b_stb && !b_ack) ? wcnt_b + 1 : 0;
        if (a_ack) acks_a <= acks_a + 1;
        if (b_ack) begin
            acks_b <= acks_b + 1;
            last_b <= b_adr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        tick(2);
        chk("rst_cyc", {31'd0, a_cyc}, 32'd0);
        chk("rst_stb", {31'd0, a_stb}, 32'd0);
        chk("rst_empty", {31'd0, a_empty}, 32'd1);
        chk("rst_rgb", {8'd0, a_r, a_g, a_b}, 32'd0);
        chk("rst_adr", a_adr, 32'd0);
        chk("rst_under", {31'd0, a_under}, 32'd0);
        chk("rst_we_sel", {27'd0, a_we, a_sel}, 32'h0000_000F);
        chk("rst_adr_b", b_adr, BASE_B);
        NRST = 1'b1;
        tick();
        chk("idle_no_bus", {31'd0, a_cyc}, 32'd0);

        // First fetches, 1-cycle ack
        fs_a = 1'b1; tick(); fs_a = 1'b0;
        chk("fetch_lat0", {31'd0, a_stb}, 32'd0);
        tick();
        chk("req0_stb", {31'd0, a_stb}, 32'd1);
        chk("req0_adr", a_adr, 32'h0);
        tick();
        chk("gap_stb", {31'd0, a_stb}, 32'd0);
        chk("adr_inc", a_adr, 32'h4);
        chk("push_lat", {31'd0, a_empty}, 32'd1);
        tick();
        chk("head0_vis", {31'd0, a_empty}, 32'd0);
        chk("head0_rgb", {8'd0, a_r, a_g, a_b}, 32'h0);
        chk("req1_stb", {31'd0, a_stb}, 32'd1);
        chk("req1_adr", a_adr, 32'h4);

        // Fill without popping: exactly FIFO_DEPTH words
        tick(600);
        chk("fill_acks", acks_a, 32'd256);
        chk("fill_stb", {31'd0, a_stb}, 32'd0);
        chk("fill_adr", a_adr, 32'h400);
        chk("fill_head", {8'd0, a_r, a_g, a_b}, 32'h0);
        rd_a = 1'b1; tick(); rd_a = 1'b0;
        chk("head1_rgb", {8'd0, a_r, a_g, a_b}, 32'h000001);
        tick();
        chk("refill_stb", {31'd0, a_stb}, 32'd1);
        chk("refill_adr", a_adr, 32'h400);
        tick(4);
        chk("refill_one", acks_a, 32'd257);
        chk("refill_idle", {31'd0, a_stb}, 32'd0);
        chk("a_no_under", {31'd0, a_under}, 32'd0);

        // Full 8x4 frame, 3-cycle ack, then continuous pops
        fs_b = 1'b1; tick(); fs_b = 1'b0;
        tick(200);
        chk("frame_acks", acks_b, 32'd32);
        chk("frame_last_adr", last_b, BASE_B + 32'h7C);
        chk("frame_done_adr", b_adr, BASE_B + 32'h80);
        chk("frame_done_stb", {31'd0, b_stb}, 32'd0);
        rd_b = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("frame_pix", {8'd0, b_r, b_g, b_b}, 32'(i));
            tick();
        end
        rd_b = 1'b0;
        chk("frame_empty", {31'd0, b_empty}, 32'd1);
        chk("frame_under", {31'd0, b_under}, 32'd0);

        // Underflow is sticky until FLUSH
        rd_b = 1'b1; tick(); rd_b = 1'b0;
        chk("uf_set", {31'd0, b_under}, 32'd1);
        chk("uf_rgb", {8'd0, b_r, b_g, b_b}, 32'h0);
        tick(3);
        chk("uf_sticky", {31'd0, b_under}, 32'd1);
        lat_b = 0;
        fs_b = 1'b1; tick(); fs_b = 1'b0;
        chk("uf_pre_flush", {31'd0, b_under}, 32'd1);
        tick();
        chk("uf_flushed", {31'd0, b_under}, 32'd0);
        chk("flush_adr", b_adr, BASE_B);
        tick();
        chk("f2_stb", {31'd0, b_stb}, 32'd1);
        chk("f2_adr", b_adr, BASE_B);
        rd_b = 1'b1; tick(3);
        chk("uf_noack", {31'd0, b_under}, 32'd1);
        chk("uf_noack_rgb", {8'd0, b_r, b_g, b_b}, 32'h0);
        chk("stb_held", {31'd0, b_stb}, 32'd1);
        chk("adr_held", b_adr, BASE_B);

        // frame_start with a pending request: drain and discard
        snap = acks_b;
        fs_b = 1'b1; tick(); fs_b = 1'b0; rd_b = 1'b0;
        chk("drain_stb", {31'd0, b_stb}, 32'd1);
        tick();
        fs_b = 1'b1; tick(); fs_b = 1'b0;
        tick(2);
        chk("drain_hold", {31'd0, b_stb}, 32'd1);
        go_b = 1'b1; tick(); go_b = 1'b0;
        chk("drain_ack", acks_b - snap, 32'd1);
        chk("drain_stb_off", {31'd0, b_stb}, 32'd0);
        chk("drain_discard", {31'd0, b_empty}, 32'd1);
        tick();
        chk("drain_empty", {31'd0, b_empty}, 32'd1);
        chk("drain_uf_clr", {31'd0, b_under}, 32'd0);
        tick();
        chk("restart_stb", {31'd0, b_stb}, 32'd1);
        chk("restart_adr", b_adr, BASE_B);

        // Reset mid-transfer aborts the cycle
        NRST = 1'b0; tick(); NRST = 1'b1;
        chk("mrst_cyc", {31'd0, b_cyc}, 32'd0);
        chk("mrst_empty", {31'd0, b_empty}, 32'd1);
        chk("mrst_adr", b_adr, BASE_B);
        tick(5);
        chk("mrst_idle", {31'd0, b_cyc}, 32'd0);
        chk("mrst_idle_a", {31'd0, a_cyc}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_fb_fetch.md
Name: vga_fb_fetch

Overview:
- Framebuffer read stage that sits directly upstream of the VGA timing/output stage.
- Acts as a Wishbone classic read master: reads one 32-bit word per pixel from a linear framebuffer, in raster order, into an internal FIFO.
- The VGA stage pops one pixel per active-display clock.
- Frame boundaries are resynchronised by a one-cycle frame_start pulse from the VGA stage.

Parameters:
- HDISP, 640, active pixels per line.
- VDISP, 480, active lines per frame.
- BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0); must be 4-byte aligned.
- FIFO_DEPTH, 256, pixel FIFO entries; power of two, at least 4.

Ports:
- CLK  in  1  system/pixel clock; all logic on posedge.
- NRST  in  1  synchronous active-low reset.
- frame_start  in  1  one-cycle pulse from the VGA stage, issued before the first active pixel of each frame.
- pix_rd  in  1  pop request from the VGA stage; asserted only during active display.
- pix_r  out  8  red of FIFO head (word bits 23:16).
- pix_g  out  8  green of FIFO head (bits 15:8).
- pix_b  out  8  blue of FIFO head (bits 7:0).
- pix_empty  out  1  FIFO empty.
- underflow  out  1  sticky; set when pix_rd occurs while the FIFO is empty.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  constant 0.
- wb_sel  out  4  constant 4'hF.
- wb_adr  out  32  byte address.
- wb_dat_i  in  32  read data; bits 31:24 ignored.
- wb_ack  in  1  Wishbone acknowledge.

Behaviour:
- Reset (NRST low at posedge CLK):
  - state=IDLE; wb_cyc=wb_stb=0; wb_adr=BASE_ADDR.
  - FIFO emptied: pix_empty=1, pix_r/g/b=0.
  - underflow=0; word index=0.
  - Reset asserted mid-cycle drops wb_cyc/wb_stb at that edge; the bus must tolerate the abort.
- State IDLE: no bus activity. frame_start -> FETCH with index=0 and wb_adr=BASE_ADDR.
- State FETCH:
  - Single outstanding request.
  - Assert wb_cyc=wb_stb=1 when (fifo_count + 1) <= FIFO_DEPTH, counting the in-flight word.
  - wb_stb/wb_adr are held stable until wb_ack.
  - On wb_ack: push wb_dat_i[23:0] into the FIFO; index+1; wb_adr+4.
  - The next request may be issued on the cycle after ack (wb_cyc/wb_stb deassert for at least one cycle between words).
  - After ack of word index HDISP*VDISP-1 -> DONE.
- State DONE: no bus activity. frame_start -> FLUSH.
- frame_start in FETCH:
  - No request pending: go to FLUSH immediately.
  - Request pending: go to DRAIN, keep wb_stb until ack, discard that word, then go to FLUSH.
- State FLUSH (one cycle): FIFO emptied; index=0; wb_adr=BASE_ADDR; underflow cleared; -> FETCH.
- frame_start in DRAIN: ignored; the pending restart is already scheduled.
- FIFO:
  - First-word-fall-through: pix_r/g/b show the head whenever pix_empty=0.
  - pix_rd && !pix_empty pops; the next head is visible on the following cycle.
  - Push and pop in the same cycle: count unchanged.
  - pix_rd on empty: no pop; underflow set; pix_r/g/b forced to 0 while empty.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- Latency:
  - First request is issued 1 cycle after entering FETCH.
  - A word acked at edge N is visible at the outputs (pix_empty=0) after edge N+1.
- The FIFO is never overrun, by construction of the request condition; an assertion checks count <= FIFO_DEPTH.

Test Plan:
- Reset, then frame_start with a memory model acking in 1 cycle where word k = k -> first wb_adr=0x0, then 0x4, 0x8…; pix_empty falls; head pix_r/g/b = 0/0/0, next head 0/0/1.
- No pix_rd after frame_start -> exactly FIFO_DEPTH (256) acks, then wb_stb stays 0; one pix_rd -> exactly one new request at adr 0x400.
- Continuous pix_rd for a full frame with 3-cycle ack latency and HDISP=8, VDISP=4 -> 32 words in order, last adr BASE+0x7C, state DONE, underflow=0.
- pix_rd held with no acks -> underflow=1 and stays 1 until the next frame_start/FLUSH; pix_r/g/b=0 while empty.
- frame_start while wb_stb is pending, ack 5 cycles later -> the acked word is not pushed; FIFO empty; next request at BASE_ADDR.
- NRST low for one cycle mid-transfer -> next cycle wb_cyc=0, pix_empty=1, IDLE; no bus activity until frame_start.
